// File: rtl/csr_trap_ctrl_pkg.sv
// Shared constants for the machine-mode trap sequencer: CSR addresses,
// exception cause codes, FSM state encoding and mstatus update helpers.
package csr_trap_ctrl_pkg;

    localparam logic [31:0] CSR_MSTATUS = 32'h0000_0300;
    localparam logic [31:0] CSR_MIE     = 32'h0000_0304;
    localparam logic [31:0] CSR_MTVEC   = 32'h0000_0305;
    localparam logic [31:0] CSR_MEPC    = 32'h0000_0341;
    localparam logic [31:0] CSR_MCAUSE  = 32'h0000_0342;

    localparam logic [31:0] CAUSE_ECALL  = 32'd11;
    localparam logic [31:0] CAUSE_EBREAK = 32'd3;

    typedef enum logic [2:0] {
        S_IDLE,
        S_W_MEPC,
        S_W_MSTAT,
        S_W_MCAUSE,
        S_JUMP,
        S_R_MSTAT,
        S_R_JUMP
    } state_t;

    // Trap entry: MPIE <= MIE, MIE <= 0, everything else untouched.
    function automatic logic [31:0] trap_mstatus(input logic [31:0] m);
        logic [31:0] r;
        r    = m;
        r[7] = m[3];
        r[3] = 1'b0;
        return r;
    endfunction

    // Trap return: MIE <= MPIE, MPIE <= 1, everything else untouched.
    function automatic logic [31:0] mret_mstatus(input logic [31:0] m);
        logic [31:0] r;
        r    = m;
        r[3] = m[7];
        r[7] = 1'b1;
        return r;
    endfunction

endpackage

// File: rtl/csr_trap_ctrl.sv
// Machine-mode trap sequencer. Takes ecall/ebreak/interrupts and mret from
// the ex stage, stalls the pipe, walks the CSR writes one per cycle on the
// dedicated trap write port, then issues a single-cycle fetch redirect.
module csr_trap_ctrl
    import csr_trap_ctrl_pkg::*;
#(
    parameter logic [31:0] MTIP_CAUSE = 32'h8000_0007,
    parameter logic [31:0] MEIP_CAUSE = 32'h8000_000B
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic [31:0] inst_addr_i,
    input  logic        ecall_i,
    input  logic        ebreak_i,
    input  logic        mret_i,
    input  logic        jump_i,
    input  logic [31:0] jump_addr_i,
    input  logic        irq_timer_i,
    input  logic        irq_ext_i,
    input  logic [31:0] csr_mtvec_i,
    input  logic [31:0] csr_mepc_i,
    input  logic [31:0] csr_mstatus_i,
    input  logic [31:0] csr_mie_i,
    output logic        csr_wen_o,
    output logic [31:0] csr_waddr_o,
    output logic [31:0] csr_wdata_o,
    output logic        hold_o,
    output logic        jump_o,
    output logic [31:0] jump_addr_o
);

    state_t      state_q, state_d;
    logic [31:0] cause_q, epc_q;
    logic        trap_trig, mret_trig;
    logic [31:0] trig_cause, trig_epc;

    // Only mie[11]/mie[7] and mtvec[31:2] matter here.
    logic unused_bits;
    assign unused_bits = ^{csr_mie_i[31:12], csr_mie_i[10:8], csr_mie_i[6:0], csr_mtvec_i[1:0]};

    // Trigger decode in IDLE with fixed priority; gated by reset so the
    // block is fully quiet while rstn is low.
    always_comb begin
        trap_trig  = 1'b0;
        mret_trig  = 1'b0;
        trig_cause = 32'h0;
        trig_epc   = 32'h0;
        if (rstn && state_q == S_IDLE) begin
            if (ecall_i) begin
                trap_trig  = 1'b1;
                trig_cause = CAUSE_ECALL;
                trig_epc   = inst_addr_i;
            end else if (ebreak_i) begin
                trap_trig  = 1'b1;
                trig_cause = CAUSE_EBREAK;
                trig_epc   = inst_addr_i;
            end else if (mret_i) begin
                mret_trig  = 1'b1;
            end else if (irq_ext_i && csr_mstatus_i[3] && csr_mie_i[11]) begin
                trap_trig  = 1'b1;
                trig_cause = MEIP_CAUSE;
                // A redirect in flight means inst_addr_i is already dead;
                // resume at the redirect target instead.
                trig_epc   = jump_i ? jump_addr_i : inst_addr_i;
            end else if (irq_timer_i && csr_mstatus_i[3] && csr_mie_i[7]) begin
                trap_trig  = 1'b1;
                trig_cause = MTIP_CAUSE;
                trig_epc   = jump_i ? jump_addr_i : inst_addr_i;
            end
        end
    end

    // Next-state and output decode; write address/data forced to 0 when idle.
    always_comb begin
        state_d     = state_q;
        csr_wen_o   = 1'b0;
        csr_waddr_o = 32'h0;
        csr_wdata_o = 32'h0;
        jump_o      = 1'b0;
        jump_addr_o = 32'h0;
        hold_o      = 1'b1;
        case (state_q)
            S_IDLE: begin
                hold_o = trap_trig | mret_trig;
                if (trap_trig)      state_d = S_W_MEPC;
                else if (mret_trig) state_d = S_R_MSTAT;
            end
            S_W_MEPC: begin
                csr_wen_o   = 1'b1;
                csr_waddr_o = CSR_MEPC;
                csr_wdata_o = epc_q;
                state_d     = S_W_MSTAT;
            end
            S_W_MSTAT: begin
                csr_wen_o   = 1'b1;
                csr_waddr_o = CSR_MSTATUS;
                csr_wdata_o = trap_mstatus(csr_mstatus_i);
                state_d     = S_W_MCAUSE;
            end
            S_W_MCAUSE: begin
                csr_wen_o   = 1'b1;
                csr_waddr_o = CSR_MCAUSE;
                csr_wdata_o = cause_q;
                state_d     = S_JUMP;
            end
            S_JUMP: begin
                jump_o      = 1'b1;
                jump_addr_o = {csr_mtvec_i[31:2], 2'b00};
                state_d     = S_IDLE;
            end
            S_R_MSTAT: begin
                csr_wen_o   = 1'b1;
                csr_waddr_o = CSR_MSTATUS;
                csr_wdata_o = mret_mstatus(csr_mstatus_i);
                state_d     = S_R_JUMP;
            end
            S_R_JUMP: begin
                jump_o      = 1'b1;
                jump_addr_o = csr_mepc_i;
                state_d     = S_IDLE;
            end
            default: begin
                hold_o  = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    // State register plus cause/epc latch captured on the trigger cycle.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q <= S_IDLE;
            cause_q <= 32'h0;
            epc_q   <= 32'h0;
        end else begin
            state_q <= state_d;
            if (trap_trig) begin
                cause_q <= trig_cause;
                epc_q   <= trig_epc;
            end
        end
    end

endmodule
